seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Time-multiplexed driver for the two-digit common-anode 7-segment display. It consumes the per-digit active-low segment patterns from the countdown timer (`seg_left`, `seg_right`) and scans them onto one shared segment bus with per-digit active-low anode enables. It also inserts a dead-time blank between digits to suppress ghosting and latches both digits once per frame so the display never tears. An optional blink mode flashes the display, for example when the countdown reaches zero.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency.
- `REFRESH_HZ`, 1000, digit-slot rate; `SLOT_TICKS = CLK_FREQ_HZ/REFRESH_HZ` cycles per slot.
- `BLANK_CYCLES`, 16, dead-time cycles at the start of each slot; requires 1 ≤ BLANK_CYCLES < SLOT_TICKS.
- `BLINK_HZ`, 2, blink rate; `BLINK_TICKS = CLK_FREQ_HZ/(2*BLINK_HZ)` cycles per half-period.
- `clk` in 1, system clock, rising edge.
- `rst_n` in 1, asynchronous, active-low reset.
- `seg_left` in 7, tens-digit pattern, active-low segments (bit 6 = g … bit 0 = a).
- `seg_right` in 7, ones-digit pattern, same encoding.
- `blink_en` in 1, when high the display flashes at BLINK_HZ.
- `seg_out` out 7, shared segment bus, active-low, registered.
- `an_n` out 2, anode enables, active-low, registered; `an_n[1]` = left digit, `an_n[0]` = right digit.

## Operation
- FSM states: BLANK_L → SHOW_L → BLANK_R → SHOW_R → BLANK_L.
- `slot_cnt` (32-bit) runs 0..SLOT_TICKS-1 within each slot:
  - BLANK_x → SHOW_x when `slot_cnt` == BLANK_CYCLES-1.
  - SHOW_x → next BLANK state when `slot_cnt` == SLOT_TICKS-1; `slot_cnt` wraps to 0.
- Output decode:
  - BLANK_x: `an_n`=2'b11, `seg_out`=7'h7F.
  - SHOW_L: `an_n`=2'b01, `seg_out`=`shadow_l`.
  - SHOW_R: `an_n`=2'b10, `seg_out`=`shadow_r`.
- Shadow capture: `shadow_l` and `shadow_r` load `seg_left`/`seg_right` together on the edge BLANK_L → SHOW_L only. Input changes at any other time take effect at the next frame.
- Blink:
  - While `blink_en`=1, `blink_cnt` counts 0..BLINK_TICKS-1, wraps, and toggles `blink_phase` on the wrap edge.
  - While `blink_en`=0, `blink_cnt` and `blink_phase` clear to 0.
  - In a SHOW state with `blink_phase`=1, outputs decode as blank.
  - The scan FSM and counters never pause for blink.
- Reset (asynchronous, immediate, clock-independent) values:
  - state BLANK_L, `slot_cnt`=0, `blink_cnt`=0, `blink_phase`=0.
  - `shadow_l`=`shadow_r`=7'h7F.
  - `an_n`=2'b11, `seg_out`=7'h7F.
- Both anodes are never low simultaneously, under any input or reset sequence.

## Timing
- Cycle numbering: cycle 0 begins at `rst_n` release; the first slot is BLANK_L with `slot_cnt`=0 in cycle 0.
- Outputs are registered from next-state decode, so in cycle c they reflect the slot position of cycle c. There is no extra pipeline lag.
- Frame = 2·SLOT_TICKS cycles. Relative to frame start:
  - cycles 0..B-1 blank.
  - cycles B..S-1 left digit.
  - cycles S..S+B-1 blank.
  - cycles S+B..2S-1 right digit.
  - (S=SLOT_TICKS, B=BLANK_CYCLES)
- Input sampling: `seg_left`/`seg_right` are sampled at the edge ending frame cycle B-1 and become visible from cycle B.
- Blink timing: `blink_phase` first goes to 1 after BLINK_TICKS consecutive cycles with `blink_en`=1, then toggles every BLINK_TICKS cycles.
  - On `blink_en` deassert, digits are visible from the next cycle that is in a SHOW state.
- Reset mid-frame: outputs go blank at `rst_n` assertion; after release the scan restarts at frame cycle 0 with blank shadows, so the display is dark until the first capture.

## Test plan
Bench parameters: CLK_FREQ_HZ=1000, REFRESH_HZ=100 (S=10), BLANK_CYCLES=2, BLINK_HZ=5 (BLINK_TICKS=100).
1. **Reset:** hold `rst_n`=0 with arbitrary inputs → `an_n`=2'b11, `seg_out`=7'h7F every cycle; never any other value.
2. **Scan:** `seg_left`=7'b1000000, `seg_right`=7'b0010010, release reset → repeating with period 20 cycles:
   - cycles 0-1 blank.
   - cycles 2-9 `an_n`=2'b01, `seg_out`=7'b1000000.
   - cycles 10-11 blank.
   - cycles 12-19 `an_n`=2'b10, `seg_out`=7'b0010010.
3. **Tear-free update:** change inputs to 7'b1111001 / 7'b0010000 at cycle 5 → cycles 12-19 still show 7'b0010010; cycles 22-29 show 7'b1111001 and cycles 32-39 show 7'b0010000.
4. **Blink:** assert `blink_en` at cycle 0 → digits visible for 100 cycles, dark (`an_n`=2'b11, `seg_out`=7'h7F) for the next 100, visible for the next 100; scan positions unchanged throughout.
5. **Blink off while dark:** deassert `blink_en` mid dark phase → the next SHOW cycle drives the digit normally; a subsequent re-assert restarts the count at 0.
6. **Async reset mid-SHOW_R:** drop `rst_n` between clock edges → outputs blank before the next edge; after release, cycles 0-1 are blank and the left digit shows the value sampled at cycle 1.
7. **Continuous check:** monitor for `an_n`==2'b00 throughout all scenarios → never occurs.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - digit pattern inputs and scanned display outputs
interface seg_scan_mux_if;
  logic [6:0] seg_left;
  logic [6:0] seg_right;
  logic       blink_en;
  logic [6:0] seg_out;
  logic [1:0] an_n;

  modport master (
    output seg_left,
    output seg_right,
    output blink_en,
    input  seg_out,
    input  an_n
  );

  modport slave (
    input  seg_left,
    input  seg_right,
    input  blink_en,
    output seg_out,
    output an_n
  );
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - two-digit 7-segment scan driver with dead-time, frame latch and blink
module seg_scan_mux #(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_HZ     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_mux_if.slave  bus
);

  localparam int unsigned SLOT_TICKS  = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int unsigned BLINK_TICKS = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam logic [31:0] SLOT_LAST   = 32'(SLOT_TICKS - 1);
  localparam logic [31:0] BLANK_LAST  = 32'(BLANK_CYCLES - 1);
  localparam logic [31:0] BLINK_LAST  = 32'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {BLANK_L, SHOW_L, BLANK_R, SHOW_R} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_slot_cnt, w_slot_cnt_nxt;
  logic [31:0] r_blink_cnt, w_blink_cnt_nxt;
  logic        r_blink_phase, w_blink_phase_nxt;
  logic [6:0]  r_shadow_l, w_shadow_l_nxt;
  logic [6:0]  r_shadow_r, w_shadow_r_nxt;
  logic [6:0]  r_seg_out, w_seg_out_nxt;
  logic [1:0]  r_an_n, w_an_n_nxt;
  logic        w_capture;

  always_comb begin
    w_state_nxt    = r_state;
    w_slot_cnt_nxt = (r_slot_cnt == SLOT_LAST) ? 32'd0 : r_slot_cnt + 32'd1;
    w_capture      = 1'b0;
    case (r_state)
      BLANK_L: if (r_slot_cnt == BLANK_LAST) begin
        w_state_nxt = SHOW_L;
        w_capture   = 1'b1;
      end
      SHOW_L:  if (r_slot_cnt == SLOT_LAST)  w_state_nxt = BLANK_R;
      BLANK_R: if (r_slot_cnt == BLANK_LAST) w_state_nxt = SHOW_R;
      SHOW_R:  if (r_slot_cnt == SLOT_LAST)  w_state_nxt = BLANK_L;
      default: w_state_nxt = BLANK_L;
    endcase

    // Both digits latch together at the start of the left digit so a frame never mixes values.
    w_shadow_l_nxt = w_capture ? bus.seg_left  : r_shadow_l;
    w_shadow_r_nxt = w_capture ? bus.seg_right : r_shadow_r;

    w_blink_cnt_nxt   = 32'd0;
    w_blink_phase_nxt = 1'b0;
    if (bus.blink_en) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_nxt   = 32'd0;
        w_blink_phase_nxt = ~r_blink_phase;
      end else begin
        w_blink_cnt_nxt   = r_blink_cnt + 32'd1;
        w_blink_phase_nxt = r_blink_phase;
      end
    end

    // Decoding the next state keeps the registered outputs aligned with the current slot.
    w_an_n_nxt    = 2'b11;
    w_seg_out_nxt = 7'h7F;
    if (!w_blink_phase_nxt) begin
      case (w_state_nxt)
        SHOW_L: begin
          w_an_n_nxt    = 2'b01;
          w_seg_out_nxt = w_shadow_l_nxt;
        end
        SHOW_R: begin
          w_an_n_nxt    = 2'b10;
          w_seg_out_nxt = w_shadow_r_nxt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BLANK_L;
      r_slot_cnt    <= 32'd0;
      r_blink_cnt   <= 32'd0;
      r_blink_phase <= 1'b0;
      r_shadow_l    <= 7'h7F;
      r_shadow_r    <= 7'h7F;
      r_seg_out     <= 7'h7F;
      r_an_n        <= 2'b11;
    end else begin
      r_state       <= w_state_nxt;
      r_slot_cnt    <= w_slot_cnt_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
      r_shadow_l    <= w_shadow_l_nxt;
      r_shadow_r    <= w_shadow_r_nxt;
      r_seg_out     <= w_seg_out_nxt;
      r_an_n        <= w_an_n_nxt;
    end
  end

  assign bus.seg_out = r_seg_out;
  assign bus.an_n    = r_an_n;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed bench for seg_scan_mux (S=10, B=2, blink half-period 100)
module tb_seg_scan_mux;

  localparam logic [6:0] L0 = 7'b1000000, R0 = 7'b0010010;
  localparam logic [6:0] L1 = 7'b1111001, R1 = 7'b0010000;
  localparam logic [6:0] L2 = 7'b0100100, R2 = 7'b0110000;
  localparam logic [6:0] L3 = 7'b0011001, R3 = 7'b0000010;
  localparam logic [6:0] L4 = 7'b1111000, R4 = 7'b0000000;
  localparam logic [6:0] L5 = 7'b0011000, R5 = 7'b0010010;
  localparam logic [8:0] DARK = {2'b11, 7'h7F};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  seg_scan_mux_if bus ();

  seg_scan_mux #(
    .CLK_FREQ_HZ (1000),
    .REFRESH_HZ  (100),
    .BLANK_CYCLES(2),
    .BLINK_HZ    (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  // Frame position: 0-1 blank, 2-9 left, 10-11 blank, 12-19 right.
  function automatic logic [8:0] exp_out(input int c, input logic [6:0] l,
                                         input logic [6:0] r, input bit dark);
    int p;
    p = c % 20;
    if (dark || p < 2 || (p >= 10 && p < 12)) return DARK;
    if (p < 10) return {2'b01, l};
    return {2'b10, r};
  endfunction

  task automatic step_check(input string tag, input logic [6:0] l,
                            input logic [6:0] r, input bit dark);
    @(negedge clk);
    check(tag, {bus.an_n, bus.seg_out}, exp_out(cyc, l, r, dark));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  always @(negedge clk) check("an_exclusive", {8'd0, bus.an_n == 2'b00}, 9'd0);

  initial begin
    bit dark;
    bus.seg_left  = 7'h00;
    bus.seg_right = 7'h00;
    bus.blink_en  = 1'b0;

    #1 rst_n = 1'b0;
    #1 check("rst_async_init", {bus.an_n, bus.seg_out}, DARK);
    for (int i = 0; i < 6; i++) begin
      bus.seg_left  = 7'($urandom);
      bus.seg_right = 7'($urandom);
      bus.blink_en  = 1'($urandom);
      @(negedge clk);
      check("rst_hold", {bus.an_n, bus.seg_out}, DARK);
    end

    bus.seg_left  = L0;
    bus.seg_right = R0;
    bus.blink_en  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      if (cyc == 5) begin
        bus.seg_left  = L1;
        bus.seg_right = R1;
      end
      if (cyc < 20) step_check("scan", L0, R0, 1'b0);
      else          step_check("tear_free", L1, R1, 1'b0);
    end

    bus.seg_left  = L2;
    bus.seg_right = R2;
    bus.blink_en  = 1'b1;
    do_reset();
    while (cyc < 480) begin
      if (cyc == 350) bus.blink_en = 1'b0;
      if (cyc == 360) bus.blink_en = 1'b1;
      dark = (cyc >= 100 && cyc < 200) || (cyc >= 300 && cyc < 351) || (cyc >= 460);
      if (cyc < 300) step_check("blink", L2, R2, dark);
      else           step_check("blink_off_on", L2, R2, dark);
    end

    bus.blink_en  = 1'b0;
    bus.seg_left  = L3;
    bus.seg_right = R3;
    do_reset();
    while (cyc < 15) step_check("pre_reset", L3, R3, 1'b0);
    @(negedge clk);
    check("show_r_before_rst", {bus.an_n, bus.seg_out}, {2'b10, R3});
    #2;
    rst_n = 1'b0;
    bus.seg_left  = L4;
    bus.seg_right = R4;
    #1 check("rst_async_mid", {bus.an_n, bus.seg_out}, DARK);
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_hold", {bus.an_n, bus.seg_out}, DARK);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    step_check("restart", L4, R4, 1'b0);
    bus.seg_left  = L5;
    bus.seg_right = R5;
    while (cyc < 20) step_check("restart", L5, R5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
